// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner: walks active-low rows, captures the lowest pressed column, then waits for release.
// Latency: each row is driven SETTLE_CYCLES+1 cycles; a key is reported one cycle after its CHECK cycle.
// Backpressure: one-entry key_code/key_valid holding register; a new key while it is still full sets sticky overrun.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 32,
  parameter int RELEASE_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] col_db,
  input  logic       key_ack,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       overrun,
  output logic       scanning
);

  localparam int MAXC = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CHECK   = 3'd2,
    HELD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      key_code_d;
  logic            key_valid_d;
  logic            overrun_d;
  logic [3:0]      row_d;
  logic            scanning_d;
  logic [1:0]      col_idx;
  logic            cols_high;

  assign cols_high = (col_db == 4'b1111);

  // Lowest-numbered low column wins when several are pressed.
  always_comb begin
    casez (col_db)
      4'b???0: col_idx = 2'd0;
      4'b??01: col_idx = 2'd1;
      4'b?011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
  end

  // Next-state, counter, key capture and registered-output precomputation.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code;
    key_valid_d = key_valid;
    overrun_d   = overrun;

    // Consumer handshake; a capture below overrides this in the same cycle.
    if (key_valid && key_ack) begin
      key_valid_d = 1'b0;
    end

    if (!scan_en) begin
      // Scan position is discarded; the key holding register is kept.
      state_d   = IDLE;
      row_idx_d = 2'd0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          row_idx_d = 2'd0;
          cnt_d     = '0;
          state_d   = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (cols_high) begin
            row_idx_d = row_idx_q + 2'd1;
            state_d   = SETTLE;
          end else begin
            state_d = HELD;
            // Register is free if empty or being drained this very cycle.
            if (!key_valid || key_ack) begin
              key_code_d  = {row_idx_q, col_idx};
              key_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        HELD: begin
          if (cols_high) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (!cols_high) begin
            cnt_d   = '0;
            state_d = HELD;
          end else if (cnt_q == RELEASE_LAST) begin
            cnt_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
            state_d   = SETTLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          row_idx_d = 2'd0;
          cnt_d     = '0;
        end
      endcase
    end

    // Row drive and scanning flag follow the next state so they change on the same edge.
    row_d      = (state_d == IDLE) ? 4'b1111 : ~(4'b0001 << row_idx_d);
    scanning_d = (state_d != IDLE);
  end

  // State and registered outputs, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_idx_q <= 2'd0;
      cnt_q     <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
      row       <= 4'b1111;
      scanning  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      overrun   <= overrun_d;
      row       <= row_d;
      scanning  <= scanning_d;
    end
  end

endmodule
